ball_motion_2d: RTL and testbench
=================================

Name: ball_motion_2d

Overview:
- Parametrised two-axis successor to the single-axis ball position generator.
- Moves a BALL_SIZE square inside an H_RES x V_RES field at a programmable per-axis step rate.
- Reflects at all four edges and reports each edge hit as a one-cycle pulse.
- Has a serve/stop/pause control FSM; feeds the VGA draw-rect stage and game logic in the pclk domain.

Parameters:
- H_RES, 1024, field width in pixels.
- V_RES, 768, field height in pixels.
- BALL_SIZE, 16, ball edge in pixels; positions are the top-left corner.
- TICK_DIV, 1_000_000, pclk cycles per movement tick (>=2).
- X_START, 504, x_pos after reset and after stop.
- Y_START, 376, y_pos after reset and after stop.

Ports:
- pclk  in  1  pixel clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; 0 on a pclk edge resets the block.
- serve  in  1  pulse; in IDLE, latches step_x/step_y/dir_x/dir_y and enters MOVE.
- stop  in  1  level/pulse; forces IDLE and recentres the ball.
- pause  in  1  level; in MOVE, freezes motion (enters PAUSE).
- step_x  in  4  pixels per tick on x, 0..15.
- step_y  in  4  pixels per tick on y, 0..15.
- dir_x  in  1  initial x direction, 1 = right.
- dir_y  in  1  initial y direction, 1 = down.
- x_pos  out  12  ball left edge.
- y_pos  out  12  ball top edge.
- moving  out  1  high in MOVE only.
- hit_left, hit_right, hit_top, hit_bottom  out  1 each  one-cycle edge-hit pulses.

Behaviour:
- Reset (reset==0 at an edge):
  - x_pos=X_START, y_pos=Y_START, state=IDLE, tick counter=TICK_DIV-1.
  - Latched steps=0; latched dirs = right/down.
  - All hit_* = 0, moving = 0.
  - Reset mid-MOVE takes effect on that same edge; no hit pulse is emitted.
- FSM states IDLE, MOVE, PAUSE, with priority stop > pause > serve:
  - IDLE -> MOVE on serve; the tick counter reloads to TICK_DIV-1 on that edge.
  - MOVE -> PAUSE while pause=1. PAUSE -> MOVE when pause=0. The tick counter holds in PAUSE.
  - Any state -> IDLE on stop. This recentres x/y to the start values and reloads the counter.
  - serve is ignored outside IDLE; serve and stop together -> IDLE.
- Tick counter: decrements each cycle in MOVE. At 0 it reloads TICK_DIV-1 and performs one move on the same edge. The first move therefore comes TICK_DIV cycles after entering MOVE.
- Move per axis (x shown; y is identical with V_RES):
  - MAX_X = H_RES-BALL_SIZE. Compute in 13 bits to avoid wrap.
  - Moving right: nxt = x+step_x.
    - If nxt >= MAX_X: x=MAX_X, dir flips to left, hit_right=1 for that cycle.
    - Otherwise x=nxt.
  - Moving left:
    - If x <= step_x: x=0, dir flips to right, hit_left=1.
    - Otherwise x = x-step_x.
  - Landing exactly on a boundary counts as a hit and flips direction.
  - step=0: the axis is static, no hits. An already-clamped position with step=0 does not re-hit.
- Corner: x and y hits on the same tick raise both pulses and flip both directions.
- Outputs are registered. x_pos/y_pos/hit_* update on the tick edge, so hit_* is coincident with the clamped position.
- Steps and directions are used only as latched at serve; changes to step_*/dir_* during MOVE have no effect.

Optional Feature:
- Macro BALL_SPEEDUP_EN.
- Defined:
  - Each hit on an axis increments that axis's latched step by 1, saturating at 15.
  - The increment is applied after the clamp, so it takes effect from the next tick.
  - A corner hit increments both axes.
- Undefined: latched steps stay constant for the whole serve.

Decomposition:
- Package ball_pkg:
  - POS_W=12, STEP_W=4, STEP_MAX=15.
  - State enum {IDLE, MOVE, PAUSE}.
  - Helper for max-position computation.
- One sub-module, ball_axis, instantiated twice (x and y), parametrised by RES/BALL_SIZE/START.
  - Inputs: move strobe, load, recentre.
  - Holds position, direction and latched step; emits lo_hit/hi_hit.
- The FSM and tick counter stay in the top level.

Test Plan:
- Bench parameters TICK_DIV=4, H_RES=64, V_RES=48, BALL_SIZE=8, start (28,20).
- Reset: reset=0 for 2 cycles -> x_pos=28, y_pos=20, moving=0, all hits 0. reset=0 during MOVE -> same values on the next edge.
- Serve: step_x=3, step_y=2, dir right/down -> moving=1; first move 4 cycles later to (31,22), then every 4 cycles.
- Clamp: ball moving right at x=54, step 3 -> x=56 (MAX_X), hit_right high exactly 1 cycle, next tick x=53.
- Corner: ball at (54,38), steps 2/2 -> (56,40), hit_right and hit_bottom in the same cycle, both dirs flip.
- Pause/stop: pause for 10 cycles mid-count -> position frozen and the residual count is resumed. stop -> (28,20) and IDLE. serve+stop together -> stays IDLE.
- BALL_SPEEDUP_EN: step_x=14, two right/left hits -> step goes 15 then stays 15. Without the macro -> step stays 14.

Source files
------------

// File: rtl/ball_pkg.sv
// ============================================================================
// Module      : ball_pkg
// Description : Shared widths, FSM state type and geometry helper for the
//               ball motion generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ball_pkg;

    localparam int POS_W    = 12;
    localparam int STEP_W   = 4;
    localparam int STEP_MAX = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Largest legal top-left coordinate so the ball stays fully inside the field.
    function automatic int max_pos(input int res, input int size);
        return res - size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ball_axis.sv
// ============================================================================
// Module      : ball_axis
// Description : One axis of ball motion: position, direction, latched step,
//               clamp-and-reflect at both edges with one-cycle hit pulses.
//               Optional BALL_SPEEDUP_EN adds +1 step (saturating) per hit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_axis
    import ball_pkg::*;
#(
    parameter int RES       = 1024,
    parameter int BALL_SIZE = 16,
    parameter int START     = 504
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_move,
    input  logic              i_load,
    input  logic              i_recentre,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_dir,
    output logic [POS_W-1:0]  o_pos,
    output logic              o_lo_hit,
    output logic              o_hi_hit
);

    localparam logic [POS_W:0]   c_MAX   = (POS_W+1)'(max_pos(RES, BALL_SIZE));
    localparam logic [POS_W-1:0] c_START = POS_W'(START);

    logic [POS_W-1:0]  r_pos;
    logic              r_dir;
    logic [STEP_W-1:0] r_step;
    logic              r_lo_hit;
    logic              r_hi_hit;

    logic [POS_W:0] w_pos_ext;
    logic [POS_W:0] w_step_ext;
    logic [POS_W:0] w_nxt_up;

    assign w_pos_ext  = {1'b0, r_pos};
    assign w_step_ext = {{(POS_W-STEP_W+1){1'b0}}, r_step};
    assign w_nxt_up   = w_pos_ext + w_step_ext;

`ifdef BALL_SPEEDUP_EN
    logic [STEP_W-1:0] w_step_inc;
    assign w_step_inc = (r_step == STEP_W'(STEP_MAX)) ? r_step : r_step + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos    <= c_START;
            r_dir    <= 1'b1;
            r_step   <= '0;
            r_lo_hit <= 1'b0;
            r_hi_hit <= 1'b0;
        end else begin
            r_lo_hit <= 1'b0;
            r_hi_hit <= 1'b0;
            if (i_recentre) begin
                r_pos <= c_START;
            end else if (i_load) begin
                r_step <= i_step;
                r_dir  <= i_dir;
            end else if (i_move && (r_step != '0)) begin
                // A zero step never hits, even when already sitting on an edge.
                if (r_dir) begin
                    if (w_nxt_up >= c_MAX) begin
                        r_pos    <= c_MAX[POS_W-1:0];
                        r_dir    <= 1'b0;
                        r_hi_hit <= 1'b1;
`ifdef BALL_SPEEDUP_EN
                        r_step   <= w_step_inc;
`endif
                    end else begin
                        r_pos <= w_nxt_up[POS_W-1:0];
                    end
                end else begin
                    if (w_pos_ext <= w_step_ext) begin
                        r_pos    <= '0;
                        r_dir    <= 1'b1;
                        r_lo_hit <= 1'b1;
`ifdef BALL_SPEEDUP_EN
                        r_step   <= w_step_inc;
`endif
                    end else begin
                        r_pos <= r_pos - POS_W'(r_step);
                    end
                end
            end
        end
    end

    assign o_pos    = r_pos;
    assign o_lo_hit = r_lo_hit;
    assign o_hi_hit = r_hi_hit;

endmodule

`default_nettype wire

// File: rtl/ball_motion_2d.sv
// ============================================================================
// Module      : ball_motion_2d
// Description : Two-axis bouncing ball generator with serve/stop/pause FSM and
//               programmable tick rate. Optional macro: BALL_SPEEDUP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_motion_2d
    import ball_pkg::*;
#(
    parameter int H_RES     = 1024,
    parameter int V_RES     = 768,
    parameter int BALL_SIZE = 16,
    parameter int TICK_DIV  = 1_000_000,
    parameter int X_START   = 504,
    parameter int Y_START   = 376
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              serve,
    input  logic              stop,
    input  logic              pause,
    input  logic [STEP_W-1:0] step_x,
    input  logic [STEP_W-1:0] step_y,
    input  logic              dir_x,
    input  logic              dir_y,
    output logic [POS_W-1:0]  x_pos,
    output logic [POS_W-1:0]  y_pos,
    output logic              moving,
    output logic              hit_left,
    output logic              hit_right,
    output logic              hit_top,
    output logic              hit_bottom
);

    localparam int                c_CNT_W  = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(TICK_DIV - 1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_moving;

    logic w_rst;
    logic w_move;
    logic w_load;

    assign w_rst  = ~reset;
    assign w_move = reset && !stop && (r_state == MOVE) && !pause && (r_cnt == '0);
    assign w_load = reset && !stop && (r_state == IDLE) && serve;

    always_ff @(posedge pclk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= c_RELOAD;
            r_moving <= 1'b0;
        end else if (stop) begin
            r_state  <= IDLE;
            r_cnt    <= c_RELOAD;
            r_moving <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (serve) begin
                        r_state  <= MOVE;
                        r_cnt    <= c_RELOAD;
                        r_moving <= 1'b1;
                    end
                end
                MOVE: begin
                    // Pausing freezes the residual count so the tick phase resumes intact.
                    if (pause) begin
                        r_state  <= PAUSE;
                        r_moving <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_cnt <= c_RELOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        r_state  <= MOVE;
                        r_moving <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= c_RELOAD;
                    r_moving <= 1'b0;
                end
            endcase
        end
    end

    assign moving = r_moving;

    ball_axis #(
        .RES       (H_RES),
        .BALL_SIZE (BALL_SIZE),
        .START     (X_START)
    ) u_axis_x (
        .clk        (pclk),
        .rst        (w_rst),
        .i_move     (w_move),
        .i_load     (w_load),
        .i_recentre (stop),
        .i_step     (step_x),
        .i_dir      (dir_x),
        .o_pos      (x_pos),
        .o_lo_hit   (hit_left),
        .o_hi_hit   (hit_right)
    );

    ball_axis #(
        .RES       (V_RES),
        .BALL_SIZE (BALL_SIZE),
        .START     (Y_START)
    ) u_axis_y (
        .clk        (pclk),
        .rst        (w_rst),
        .i_move     (w_move),
        .i_load     (w_load),
        .i_recentre (stop),
        .i_step     (step_y),
        .i_dir      (dir_y),
        .o_pos      (y_pos),
        .o_lo_hit   (hit_top),
        .o_hi_hit   (hit_bottom)
    );

endmodule

`default_nettype wire

// File: tb/tb_ball_motion_2d.sv
// ============================================================================
// Module      : tb_ball_motion_2d
// Description : Directed table-driven bench for ball_motion_2d on a small
//               64x48 field with an 8-pixel ball and a 4-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_motion_2d;

    logic        pclk;
    logic        reset;
    logic        serve;
    logic        stop;
    logic        pause;
    logic [3:0]  step_x;
    logic [3:0]  step_y;
    logic        dir_x;
    logic        dir_y;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        moving;
    logic        hit_left;
    logic        hit_right;
    logic        hit_top;
    logic        hit_bottom;

    int checks   = 0;
    int failures = 0;

    ball_motion_2d #(
        .H_RES     (64),
        .V_RES     (48),
        .BALL_SIZE (8),
        .TICK_DIV  (4),
        .X_START   (28),
        .Y_START   (20)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .serve      (serve),
        .stop       (stop),
        .pause      (pause),
        .step_x     (step_x),
        .step_y     (step_y),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .moving     (moving),
        .hit_left   (hit_left),
        .hit_right  (hit_right),
        .hit_top    (hit_top),
        .hit_bottom (hit_bottom)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Hit vector order: {left, right, top, bottom}
    typedef struct {
        logic       rst_n;
        logic       srv;
        logic       stp;
        logic       pse;
        logic [3:0] sx;
        logic [3:0] sy;
        logic       dx;
        logic       dy;
        int         ncyc;
        int         ex;
        int         ey;
        logic       emov;
        logic [3:0] ehit;
    } vec_t;

    vec_t tbl[15];

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input int ex, input int ey,
                         input logic emov, input logic [3:0] ehit);
        logic [3:0] hits;
        hits = {hit_left, hit_right, hit_top, hit_bottom};
        checks++;
        if (x_pos !== 12'(ex) || y_pos !== 12'(ey) || moving !== emov || hits !== ehit) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d moving=%b hits=%b, expected x=%0d y=%0d moving=%b hits=%b",
                     name, x_pos, y_pos, moving, hits, ex, ey, emov, ehit);
        end
    endtask

    task automatic drive(input logic r, input logic sv, input logic st, input logic ps,
                         input logic [3:0] sx, input logic [3:0] sy,
                         input logic dx, input logic dy);
        reset  = r;
        serve  = sv;
        stop   = st;
        pause  = ps;
        step_x = sx;
        step_y = sy;
        dir_x  = dx;
        dir_y  = dy;
    endtask

    initial begin
        int n_rows;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1,  2, 28, 20, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd2, 1'b1, 1'b1,  1, 28, 20, 1'b1, 4'b0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  2, 28, 20, 1'b1, 4'b0000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  1, 28, 20, 1'b1, 4'b0000};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  1, 31, 22, 1'b1, 4'b0000};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  4, 34, 24, 1'b1, 4'b0000};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0, 24, 52, 36, 1'b1, 4'b0000};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  4, 55, 38, 1'b1, 4'b0000};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  4, 56, 40, 1'b1, 4'b0101};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  1, 56, 40, 1'b1, 4'b0000};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  3, 53, 38, 1'b1, 4'b0000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0, 68,  2,  4, 1'b1, 4'b0000};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  4,  0,  2, 1'b1, 4'b1000};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  4,  3,  0, 1'b1, 4'b0010};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0,  1,  3,  0, 1'b1, 4'b0000};

`ifdef BALL_SPEEDUP_EN
        n_rows = 10;    // steps grow after the corner, so later rows assume a fixed step
`else
        n_rows = 15;
`endif

        for (int i = 0; i < n_rows; i++) begin
            drive(tbl[i].rst_n, tbl[i].srv, tbl[i].stp, tbl[i].pse,
                  tbl[i].sx, tbl[i].sy, tbl[i].dx, tbl[i].dy);
            cyc(tbl[i].ncyc);
            check($sformatf("row%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].emov, tbl[i].ehit);
        end

        // Stop recentres and returns to IDLE
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(1);
        check("stop_recentre", 28, 20, 1'b0, 4'b0000);

        // Pause mid-count: serve, burn 2 counts, pause 10 cycles, resume residual
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(1);
        check("serve2", 28, 20, 1'b1, 4'b0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(2);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(10);
        check("paused", 28, 20, 1'b0, 4'b0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(2);
        check("resume_residual", 28, 20, 1'b1, 4'b0000);
        cyc(1);
        check("resume_move", 29, 21, 1'b1, 4'b0000);

        // Stop during MOVE
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(1);
        check("stop_in_move", 28, 20, 1'b0, 4'b0000);

        // serve and stop together stays IDLE
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(6);
        check("serve_stop_idle", 28, 20, 1'b0, 4'b0000);

        // Reset during MOVE
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(4);
        check("pre_reset_move", 29, 21, 1'b1, 4'b0000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        cyc(1);
        check("reset_mid_move", 28, 20, 1'b0, 4'b0000);

        // Step 14 on x, static y: two edge hits
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd14, 4'd0, 1'b1, 1'b1);
        cyc(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc(4);
        check("spd_t1", 42, 20, 1'b1, 4'b0000);
        cyc(4);
        check("spd_hit_right", 56, 20, 1'b1, 4'b0100);
`ifdef BALL_SPEEDUP_EN
        cyc(4); check("spd_t3", 41, 20, 1'b1, 4'b0000);
        cyc(4); check("spd_t4", 26, 20, 1'b1, 4'b0000);
        cyc(4); check("spd_t5", 11, 20, 1'b1, 4'b0000);
        cyc(4); check("spd_hit_left", 0, 20, 1'b1, 4'b1000);
        cyc(4); check("spd_sat", 15, 20, 1'b1, 4'b0000);
`else
        cyc(4); check("spd_t3", 42, 20, 1'b1, 4'b0000);
        cyc(4); check("spd_t4", 28, 20, 1'b1, 4'b0000);
        cyc(4); check("spd_t5", 14, 20, 1'b1, 4'b0000);
        cyc(4); check("spd_hit_left", 0, 20, 1'b1, 4'b1000);
        cyc(4); check("spd_const", 14, 20, 1'b1, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
